// File: rtl/dmem_arbiter_pkg.sv
// Shared encodings for the data-BRAM arbiter: FSM states and read-return owner tags.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_RUN   = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_LDR  = 2'd2
  } rd_owner_e;

endpackage

// File: rtl/dmem_arbiter_wait_counter.sv
// Saturating starvation counter: counts consecutive loader-denied cycles up to MAX_WAIT.
module arb_wait_counter #(
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = $clog2(MAX_WAIT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             at_max
);

  assign at_max = (cnt == CNT_W'(MAX_WAIT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (inc && !at_max)
      cnt <= cnt + CNT_W'(1);
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data BRAM arbiter between the MEM-stage CPU port and the UART boot loader.
// BOOT serves the loader only; RUN favours the CPU with a starvation guard for the loader.
//
// state    | meaning
// ST_BOOT  | loader owns the BRAM, CPU requests are stalled
// ST_DRAIN | one-cycle gap on a mode change, no grants, in-flight read returns
// ST_RUN   | CPU priority, loader forced in after MAX_WAIT denied cycles
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W   = 14,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              boot_mode,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic              ldr_gnt,
  output logic              ldr_rvalid,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  arb_state_e state;
  arb_state_e drain_tgt;
  rd_owner_e  rd_owner;
  logic       cpu_rpend;
  logic       cpu_oor_q;
  logic       cpu_gnt;
  logic       cpu_addr_ok;
  logic       wait_inc;
  logic       wait_at_max;
  logic [CNT_W-1:0] wait_cnt;
  logic       unused_addr_lsb;

  assign unused_addr_lsb = ^cpu_addr[1:0];
  assign cpu_addr_ok     = (cpu_addr[31:ADDR_W+2] == '0);

  // Starvation only accrues while the CPU can actually win arbitration.
  assign wait_inc = (state == ST_RUN) && ldr_req && !ldr_gnt;

  arb_wait_counter #(
    .MAX_WAIT (MAX_WAIT),
    .CNT_W    (CNT_W)
  ) u_wait_counter (
    .clk    (clk),
    .rst    (rst),
    .clr    (!wait_inc),
    .inc    (wait_inc),
    .cnt    (wait_cnt),
    .at_max (wait_at_max)
  );

  always_comb begin
    ldr_gnt   = 1'b0;
    cpu_gnt   = 1'b0;
    cpu_stall = 1'b0;
    case (state)
      ST_BOOT: begin
        ldr_gnt   = ldr_req;
        cpu_stall = cpu_req;
      end
      ST_DRAIN: begin
        cpu_stall = cpu_req && !cpu_rpend;
      end
      ST_RUN: begin
        if (cpu_rpend) begin
          ldr_gnt = ldr_req;
        end else if (cpu_req && ldr_req) begin
          if (wait_at_max)
            ldr_gnt = 1'b1;
          else
            cpu_gnt = 1'b1;
        end else begin
          cpu_gnt = cpu_req;
          ldr_gnt = ldr_req;
        end
        cpu_stall = cpu_req && !cpu_rpend && !(cpu_gnt && cpu_we);
      end
      default: begin
        cpu_stall = cpu_req;
      end
    endcase
  end

  // Out-of-range CPU accesses are granted but never reach the BRAM.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_gnt) begin
      mem_en    = cpu_addr_ok;
      mem_we    = cpu_addr_ok && cpu_we;
      mem_addr  = cpu_addr[ADDR_W+1:2];
      mem_wdata = cpu_wdata;
    end else if (ldr_gnt) begin
      mem_en    = 1'b1;
      mem_we    = ldr_we;
      mem_addr  = ldr_addr;
      mem_wdata = ldr_wdata;
    end
  end

  assign cpu_rdata = (rd_owner == OWN_CPU && !cpu_oor_q) ? mem_rdata : '0;
  assign ldr_rdata = ldr_rvalid ? mem_rdata : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_BOOT;
      drain_tgt  <= ST_BOOT;
      cpu_rpend  <= 1'b0;
      cpu_oor_q  <= 1'b0;
      rd_owner   <= OWN_NONE;
      ldr_rvalid <= 1'b0;
    end else begin
      case (state)
        ST_BOOT: begin
          if (!boot_mode) begin
            state     <= ST_DRAIN;
            drain_tgt <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (boot_mode) begin
            state     <= ST_DRAIN;
            drain_tgt <= ST_BOOT;
          end
        end
        ST_DRAIN: state <= drain_tgt;
        default:  state <= ST_BOOT;
      endcase
      cpu_rpend  <= cpu_gnt && !cpu_we;
      cpu_oor_q  <= cpu_gnt && !cpu_addr_ok;
      ldr_rvalid <= ldr_gnt && !ldr_we;
      if (cpu_gnt && !cpu_we)
        rd_owner <= OWN_CPU;
      else if (ldr_gnt && !ldr_we)
        rd_owner <= OWN_LDR;
      else
        rd_owner <= OWN_NONE;
    end
  end

endmodule
